enc_dispatch: RTL and testbench

//   Downstream consumer of the 4-to-2 priority encoder.

---
 rtl/enc_dispatch.sv | 112 +++++++++++
 tb/tb_enc_dispatch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc_dispatch.sv
// enc_dispatch: samples a valid 4-to-2 priority encoder result, runs a
// req/ack handshake with one service handler, then pulses a one-hot clear
// back to the request source. Completed services and timeouts are counted
// in saturating counters. Every output comes straight from a flop.
module enc_dispatch #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       enc_y,
  output logic             req,
  output logic [1:0]       req_idx,
  input  logic             ack,
  output logic [3:0]       clr,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Timer only has to reach HOLD_MAX-1; keep it at least one bit wide.
  localparam int TW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [TW-1:0] TMAX = TW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       req_idx_q, req_idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       clr_q, clr_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Next state, datapath updates and the registered output values.
  always_comb begin
    state_d    = state_q;
    req_idx_d  = req_idx_q;
    timer_d    = timer_q;
    clr_d      = '0;
    timeout_d  = 1'b0;
    done_cnt_d = done_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        // Only a fully known, valid encoder result starts a service;
        // a valid bit or index carrying X/Z is treated as no request.
        if (enc_y[2] === 1'b1 && !$isunknown(enc_y[1:0])) begin
          req_idx_d = enc_y[1:0];
          timer_d   = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        timer_d = timer_q + 1'b1;
        // ack has priority over an expiry in the same cycle.
        if (ack) begin
          state_d = DONE;
        end else if (timer_q == TMAX) begin
          timeout_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        clr_d = 4'b0001 << req_idx_q;
        if (done_cnt_q != '1) done_cnt_d = done_cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_idx_q  <= '0;
      timer_q    <= '0;
      clr_q      <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      done_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_idx_q  <= req_idx_d;
      timer_q    <= timer_d;
      clr_q      <= clr_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      done_cnt_q <= done_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign req      = req_q;
  assign req_idx  = req_idx_q;
  assign clr      = clr_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign done_cnt = done_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_enc_dispatch.sv
// Directed bench for enc_dispatch. A second instance with CNT_W=2 sees the
// same stimulus so counter saturation can be observed.
module tb_enc_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] enc_y;
  logic       ack;
  logic       req, busy, timeout;
  logic [1:0] req_idx;
  logic [3:0] clr;
  logic [7:0] done_cnt, err_cnt;
  logic       req2, busy2, timeout2;
  logic [1:0] req_idx2;
  logic [3:0] clr2;
  logic [1:0] done_cnt2, err_cnt2;

  int nvec = 0;
  int nerr = 0;
  int exp_done = 0;
  int exp_err  = 0;

  enc_dispatch #(.HOLD_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enc_y(enc_y), .req(req), .req_idx(req_idx),
    .ack(ack), .clr(clr), .busy(busy), .timeout(timeout),
    .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  enc_dispatch #(.HOLD_MAX(15), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enc_y(enc_y), .req(req2), .req_idx(req_idx2),
    .ack(ack), .clr(clr2), .busy(busy2), .timeout(timeout2),
    .done_cnt(done_cnt2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs
  // sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake for one encoder value, ack on the first REQ cycle.
  task automatic serve(input logic [2:0] y, input logic [1:0] eidx, input logic [3:0] eclr,
                       input string nm);
    enc_y = y; ack = 1'b0;
    tick();
    nvec++;
    if (req !== 1'b1 || req_idx !== eidx) begin
      nerr++; $display("FAIL %s req: got req=%b idx=%b want req=1 idx=%b", nm, req, req_idx, eidx);
    end
    enc_y = 3'b000; ack = 1'b1;
    tick();
    nvec++;
    if (req !== 1'b0 || busy !== 1'b1 || clr !== 4'b0000) begin
      nerr++; $display("FAIL %s done_state: got req=%b busy=%b clr=%b want 0 1 0000", nm, req, busy, clr);
    end
    ack = 1'b0;
    tick();
    exp_done++;
    nvec++;
    if (clr !== eclr || busy !== 1'b0 || done_cnt !== 8'(exp_done)) begin
      nerr++; $display("FAIL %s clr: got clr=%b busy=%b done=%0d want clr=%b busy=0 done=%0d",
                       nm, clr, busy, done_cnt, eclr, exp_done);
    end
    tick();
    nvec++;
    if (clr !== 4'b0000 || req !== 1'b0) begin
      nerr++; $display("FAIL %s clr_pulse: got clr=%b req=%b want 0000 0", nm, clr, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enc_y = 3'b111; ack = 1'b0;
    tick(); tick();
    nvec++;
    if (req !== 1'b0 || busy !== 1'b0 || clr !== 4'b0000 || timeout !== 1'b0 ||
        done_cnt !== 8'd0 || err_cnt !== 8'd0 || req_idx !== 2'b00) begin
      nerr++; $display("FAIL reset: got req=%b busy=%b clr=%b to=%b done=%0d err=%0d idx=%b want all zero",
                       req, busy, clr, timeout, done_cnt, err_cnt, req_idx);
    end
    rst = 1'b0;
    serve(3'b111, 2'b11, 4'b1000, "reset_release");
  endtask

  task automatic test_service();
    serve(3'b101, 2'b01, 4'b0010, "service_101");
  endtask

  task automatic test_timeout();
    int n = 0;
    enc_y = 3'b110; ack = 1'b0;
    tick();
    while (req === 1'b1 && n < 40) begin
      n++;
      if (clr !== 4'b0000) begin
        nerr++; $display("FAIL timeout_clr: got clr=%b want 0000 while req", clr);
      end
      enc_y = 3'b000;
      tick();
    end
    exp_err++;
    nvec++;
    if (n != 15) begin
      nerr++; $display("FAIL timeout_len: got %0d req cycles want 15", n);
    end
    nvec++;
    if (timeout !== 1'b1 || err_cnt !== 8'(exp_err) || clr !== 4'b0000 || busy !== 1'b0 ||
        done_cnt !== 8'(exp_done)) begin
      nerr++; $display("FAIL timeout_pulse: got to=%b err=%0d clr=%b busy=%b done=%0d want 1 %0d 0000 0 %0d",
                       timeout, err_cnt, clr, busy, done_cnt, exp_err, exp_done);
    end
    tick();
    nvec++;
    if (timeout !== 1'b0) begin
      nerr++; $display("FAIL timeout_once: got to=%b want 0", timeout);
    end
  endtask

  task automatic test_ack_at_expiry();
    enc_y = 3'b111; ack = 1'b0;
    tick();
    enc_y = 3'b000;
    for (int i = 0; i < 14; i++) tick();
    nvec++;
    if (req !== 1'b1) begin
      nerr++; $display("FAIL expiry_hold: got req=%b want 1 at last timer cycle", req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    nvec++;
    if (timeout !== 1'b0 || req !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL expiry_ack: got to=%b req=%b busy=%b want 0 0 1", timeout, req, busy);
    end
    tick();
    exp_done++;
    nvec++;
    if (clr !== 4'b1000 || timeout !== 1'b0 || done_cnt !== 8'(exp_done) || err_cnt !== 8'(exp_err)) begin
      nerr++; $display("FAIL expiry_done: got clr=%b to=%b done=%0d err=%0d want 1000 0 %0d %0d",
                       clr, timeout, done_cnt, err_cnt, exp_done, exp_err);
    end
    tick();
  endtask

  task automatic test_idle_ignore();
    logic [2:0] ys [3];
    ys[0] = 3'b000; ys[1] = 3'b0xx; ys[2] = 3'b011;
    for (int i = 0; i < 3; i++) begin
      enc_y = ys[i];
      for (int k = 0; k < 3; k++) begin
        ack = k[0];
        tick();
        nvec++;
        if (req !== 1'b0 || busy !== 1'b0 || done_cnt !== 8'(exp_done) || err_cnt !== 8'(exp_err)) begin
          nerr++; $display("FAIL idle_ignore[%0d]: got req=%b busy=%b done=%0d err=%0d want 0 0 %0d %0d",
                           i, req, busy, done_cnt, err_cnt, exp_done, exp_err);
        end
      end
    end
    ack = 1'b0; enc_y = 3'b000;
  endtask

  task automatic test_back_to_back();
    serve(3'b111, 2'b11, 4'b1000, "seq_1111");
    serve(3'b111, 2'b11, 4'b1000, "seq_1010");
    serve(3'b111, 2'b11, 4'b1000, "seq_1100");
    serve(3'b111, 2'b11, 4'b1000, "seq_1000");
    serve(3'b100, 2'b00, 4'b0001, "seq_0001");
    nvec++;
    if (done_cnt2 !== 2'd3 || err_cnt2 !== 2'd1) begin
      nerr++; $display("FAIL saturate: got done2=%0d err2=%0d want 3 1", done_cnt2, err_cnt2);
    end
  endtask

  task automatic test_reset_mid();
    enc_y = 3'b110; ack = 1'b0;
    tick();
    enc_y = 3'b000; rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (req !== 1'b0 || busy !== 1'b0 || done_cnt !== 8'd0 || err_cnt !== 8'd0 || done_cnt2 !== 2'd0) begin
      nerr++; $display("FAIL rst_req: got req=%b busy=%b done=%0d err=%0d done2=%0d want 0 0 0 0 0",
                       req, busy, done_cnt, err_cnt, done_cnt2);
    end
    enc_y = 3'b101;
    tick();
    enc_y = 3'b000; ack = 1'b1;
    tick();
    ack = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (clr !== 4'b0000 || done_cnt !== 8'd0 || busy !== 1'b0) begin
      nerr++; $display("FAIL rst_done: got clr=%b done=%0d busy=%b want 0000 0 0", clr, done_cnt, busy);
    end
    tick();
    nvec++;
    if (clr !== 4'b0000 || req !== 1'b0) begin
      nerr++; $display("FAIL rst_done_after: got clr=%b req=%b want 0000 0", clr, req);
    end
  endtask

  initial begin
    test_reset();
    test_service();
    test_timeout();
    test_ack_at_expiry();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Backstop so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
